mux_fifo_sched: RTL

//  Round-robin scheduler sharing one mux_fifo_core among NUM_REQ packet requesters.

---
 rtl/mux_fifo_pkg.sv | 23 ++
 rtl/mux_fifo_sched_rr_arb.sv | 36 +++
 rtl/mux_fifo_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mux_fifo_pkg.sv
// mux_fifo_pkg
//   Shared types and width helpers for the mux_fifo scheduler slice.
//   sched_state_t : scheduler FSM state encoding.
//   calc_units    : data beat width / unit width -> units per beat.
//   calc_ofst_w   : unit-offset field width for a given units-per-beat.
package mux_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_t;

  function automatic int unsigned calc_units(input int unsigned data_width,
                                             input int unsigned data_unit);
    return data_width / data_unit;
  endfunction

  function automatic int unsigned calc_ofst_w(input int unsigned units);
    return (units > 1) ? $clog2(units) : 1;
  endfunction

endpackage

// File: rtl/mux_fifo_sched_rr_arb.sv
// mux_fifo_rr_arb
//   Combinational masked round-robin picker.
//   req : per-requester request vector
//   ptr : last served requester; search starts at ptr+1 and wraps
//   gnt : one-hot grant (zero when no request)
//   id  : index of the granted requester
//   any : at least one request present
module mux_fifo_rr_arb #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/mux_fifo_sched.sv
// mux_fifo_sched
//   Round-robin scheduler sharing one mux_fifo_core among NUM_REQ requesters.
//   A requester's command (length in units, src/dst offsets, last, user) is
//   accepted in IDLE, then its data beats are streamed into the core src_*
//   interface with per-beat bgin/done/unit_num/offset. flush_req aborts the
//   current packet and pulses core_flush for one cycle.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     flush_req             abort + flush core
//     cmd_*                 per-requester command (flattened, requester 0 in LSBs)
//     req_data*             per-requester data stream
//     core_*                to/from the shared mux_fifo_core
//     busy, grant_id        scheduler status
module mux_fifo_sched
  import mux_fifo_pkg::*;
#(
  parameter  int unsigned NUM_REQ         = 4,
  parameter  int unsigned DATA_WIDTH      = 32,
  parameter  int unsigned DATA_UNIT       = 8,
  parameter  int unsigned USER_INFO_WIDTH = 8,
  parameter  int unsigned LEN_WIDTH       = 16,
  localparam int unsigned UNITS           = calc_units(DATA_WIDTH, DATA_UNIT),
  localparam int unsigned OFST_W          = calc_ofst_w(UNITS),
  localparam int unsigned PTR_W           = OFST_W + 1,
  localparam int unsigned ID_W            = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_req,
  input  logic [NUM_REQ-1:0]             cmd_valid,
  output logic [NUM_REQ-1:0]             cmd_ready,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   cmd_len,
  input  logic [NUM_REQ*OFST_W-1:0]      cmd_src_ofst,
  input  logic [NUM_REQ*OFST_W-1:0]      cmd_dst_ofst,
  input  logic [NUM_REQ-1:0]             cmd_last,
  input  logic [NUM_REQ*USER_INFO_WIDTH-1:0] cmd_user,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_data_valid,
  output logic [NUM_REQ-1:0]             req_data_ready,
  output logic                           core_flush,
  output logic [DATA_WIDTH-1:0]          core_src_data,
  output logic                           core_src_valid,
  input  logic                           core_src_ready,
  output logic                           core_src_bgin,
  output logic [PTR_W-1:0]               core_src_unit_num,
  output logic                           core_src_done,
  output logic                           core_src_last,
  output logic [OFST_W-1:0]              core_src_offset,
  output logic [OFST_W-1:0]              core_src_initial_offset,
  output logic [USER_INFO_WIDTH-1:0]     core_src_user_info,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  typedef struct packed {
    logic [OFST_W-1:0]          src_ofst;
    logic [OFST_W-1:0]          dst_ofst;
    logic                       last;
    logic [USER_INFO_WIDTH-1:0] user;
  } sched_cmd_t;

  sched_state_t         state_q, state_d;
  sched_cmd_t           cmd_q, cmd_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 first_q, first_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;

  logic [LEN_WIDTH-1:0]       len_a  [NUM_REQ];
  logic [OFST_W-1:0]          sofs_a [NUM_REQ];
  logic [OFST_W-1:0]          dofs_a [NUM_REQ];
  logic [USER_INFO_WIDTH-1:0] user_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]      data_a [NUM_REQ];

  logic [NUM_REQ-1:0]   arb_req, arb_gnt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_any;
  logic                 xfer, active, hs, done;
  logic [LEN_WIDTH-1:0] avail, take;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      len_a[i]  = cmd_len[i*LEN_WIDTH +: LEN_WIDTH];
      sofs_a[i] = cmd_src_ofst[i*OFST_W +: OFST_W];
      dofs_a[i] = cmd_dst_ofst[i*OFST_W +: OFST_W];
      user_a[i] = cmd_user[i*USER_INFO_WIDTH +: USER_INFO_WIDTH];
      data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Masking requests during flush_req keeps the accept path quiet that cycle.
  assign arb_req = flush_req ? '0 : cmd_valid;

  mux_fifo_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req (arb_req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  assign xfer   = (state_q == ST_XFER);
  assign active = xfer && !flush_req;
  assign avail  = first_q ? (LEN_WIDTH'(UNITS) - LEN_WIDTH'(cmd_q.src_ofst))
                          : LEN_WIDTH'(UNITS);
  assign done   = (remaining_q <= avail);
  assign take   = done ? remaining_q : avail;
  assign hs     = core_src_valid && core_src_ready;

  assign cmd_ready      = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign req_data_ready = active ? (NUM_REQ'(core_src_ready) << grant_q) : '0;
  assign core_src_valid = active && req_data_valid[grant_q];
  assign core_src_data  = xfer ? data_a[grant_q] : '0;
  assign core_src_bgin  = xfer && first_q;
  assign core_src_unit_num       = xfer ? PTR_W'(take) : '0;
  assign core_src_done           = xfer && done;
  assign core_src_last           = xfer && done && cmd_q.last;
  assign core_src_offset         = (xfer && first_q) ? cmd_q.src_ofst : '0;
  assign core_src_initial_offset = xfer ? cmd_q.dst_ofst : '0;
  assign core_src_user_info      = xfer ? cmd_q.user : '0;
  assign core_flush = (state_q == ST_FLUSH);
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = grant_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    first_d     = first_q;
    remaining_d = remaining_q;
    if (flush_req) begin
      state_d = ST_FLUSH;
      // Only an in-flight packet hands its priority away.
      if (xfer) rr_d = grant_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_d        = arb_id;
            cmd_d.src_ofst = sofs_a[arb_id];
            cmd_d.dst_ofst = dofs_a[arb_id];
            cmd_d.last     = cmd_last[arb_id];
            cmd_d.user     = user_a[arb_id];
            if (len_a[arb_id] == '0) begin
              rr_d = arb_id;
            end else begin
              remaining_d = len_a[arb_id];
              first_d     = 1'b1;
              state_d     = ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (hs) begin
            remaining_d = remaining_q - take;
            first_d     = 1'b0;
            if (done) begin
              rr_d    = grant_q;
              state_d = ST_IDLE;
            end
          end
        end
        ST_FLUSH: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rr_q        <= ID_W'(NUM_REQ - 1);
      grant_q     <= '0;
      first_q     <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      remaining_q <= remaining_d;
    end
  end

endmodule
